// File: rtl/io_sequencer_pkg.sv
// io_seq_pkg: shared definitions for the board I/O sequencer.
//   state_t      - 4-bit state codes S0..S15, values match the I/O block decode
//   BTN_*        - bit positions of the used buttons
//   MODE_*       - Slide_Switch values selecting a path from Idle
package io_seq_pkg;

    typedef enum logic [3:0] {
        S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,
        S4  = 4'd4,  S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,
        S8  = 4'd8,  S9  = 4'd9,  S10 = 4'd10, S11 = 4'd11,
        S12 = 4'd12, S13 = 4'd13, S14 = 4'd14, S15 = 4'd15
    } state_t;

    localparam int BTN_CONFIRM = 0;
    localparam int BTN_CANCEL  = 1;

    localparam logic [3:0] MODE_SAVE  = 4'd1;
    localparam logic [3:0] MODE_READ  = 4'd2;
    localparam logic [3:0] MODE_INSTR = 4'd3;

endpackage

// File: rtl/io_sequencer_if.sv
// io_sequencer_if: register-file and execution-datapath connection.
//   master - the sequencer (drives address/data/strobes/instruction)
//   slave  - the register file + datapath side
interface io_sequencer_if;
    logic [3:0]  Mem_Addr;
    logic [7:0]  Mem_Wdata;
    logic        Mem_We;
    logic        Mem_Re;
    logic [7:0]  Mem_Rdata;
    logic [15:0] Instr;
    logic        Exec_Start;
    logic        Exec_Done;
    logic [15:0] Exec_Result;

    modport master (
        output Mem_Addr, Mem_Wdata, Mem_We, Mem_Re, Instr, Exec_Start,
        input  Mem_Rdata, Exec_Done, Exec_Result
    );

    modport slave (
        input  Mem_Addr, Mem_Wdata, Mem_We, Mem_Re, Instr, Exec_Start,
        output Mem_Rdata, Exec_Done, Exec_Result
    );
endinterface

// File: rtl/io_sequencer_debouncer.sv
// button_debouncer: synchronises one raw button and accepts a new level only
// after DEBOUNCE_CYCLES consecutive samples differing from the current level.
//   clk, rst_n - clock, async active-low reset
//   raw        - raw button input (asynchronous)
//   level      - debounced level
//   press      - one-cycle pulse on each accepted rising edge
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Down-counter restarts whenever the sample agrees with the accepted level,
    // so any glitch shorter than the window is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            cnt   <= RELOAD;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync[1];
                press <= sync[1];
                cnt   <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_sequencer.sv
// io_sequencer: board-interaction controller. Turns debounced buttons and the
// slide-switch nibble into register-file writes/reads and instruction issue,
// and supplies the State code and 16-bit display word to the I/O block.
//   CLK, RST_N    - 10 kHz clock, async active-low reset
//   Slide_Switch  - nibble entry / mode select
//   Button        - [0] confirm, [1] cancel, [3:2] unused
//   bus (master)  - register-file and datapath connection
//   State, Result - state code and display word
//   Exec_Err      - execution timeout flag
// Optional: define IO_SEQ_EXEC_TIMEOUT_EN to add the S14 wait timeout.
module io_sequencer
    import io_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [3:0]            Slide_Switch,
    input  logic [3:0]            Button,
    io_sequencer_if.master        bus,
    output logic [3:0]            State,
    output logic [15:0]           Result,
    output logic                  Exec_Err
);
    // State table
    // S0  | one cycle after reset
    // S1  | idle, mode select
    // S2  | save: enter address
    // S3  | save: enter data
    // S4  | save: written, show data
    // S5  | read: enter address
    // S6  | read: show read data
    // S8  | instr: opcode nibble
    // S9  | instr: srcA nibble
    // S10 | instr: srcB nibble
    // S12 | instr: dest nibble
    // S14 | waiting for execution
    // S15 | show execution result

    logic [1:0] btn_press;
    logic [1:0] btn_level_unused;
    logic       unused_btn;
    assign unused_btn = ^Button[3:2];

    for (genvar i = 0; i < 2; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (CLK),
            .rst_n (RST_N),
            .raw   (Button[i]),
            .level (btn_level_unused[i]),
            .press (btn_press[i])
        );
    end

    logic confirm, cancel;
    assign cancel  = btn_press[BTN_CANCEL];
    assign confirm = btn_press[BTN_CONFIRM] & ~cancel;

    state_t      state, state_nxt;
    logic        ld_addr, ld_wdata, we_nxt, re_nxt, start_nxt, ld_res;
    logic [3:0]  ld_nib;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata, read_reg;
    logic [15:0] instr, res_reg;
    logic        mem_we, mem_re, exec_start, rd_pend;

`ifdef IO_SEQ_EXEC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_hit, exec_err;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_addr   = 1'b0;
        ld_wdata  = 1'b0;
        we_nxt    = 1'b0;
        re_nxt    = 1'b0;
        start_nxt = 1'b0;
        ld_res    = 1'b0;
        ld_nib    = 4'b0000;
`ifdef IO_SEQ_EXEC_TIMEOUT_EN
        to_hit    = 1'b0;
`endif
        case (state)
            S0: state_nxt = S1;
            S1: if (confirm) begin
                case (Slide_Switch)
                    MODE_SAVE:  state_nxt = S2;
                    MODE_READ:  state_nxt = S5;
                    MODE_INSTR: state_nxt = S8;
                    default:    state_nxt = S1;
                endcase
            end
            S2: if (cancel) state_nxt = S1;
                else if (confirm) begin ld_addr = 1'b1; state_nxt = S3; end
            S3: if (cancel) state_nxt = S1;
                else if (confirm) begin ld_wdata = 1'b1; we_nxt = 1'b1; state_nxt = S4; end
            S5: if (cancel) state_nxt = S1;
                else if (confirm) begin ld_addr = 1'b1; re_nxt = 1'b1; state_nxt = S6; end
            S4, S6, S15: if (confirm || cancel) state_nxt = S1;
            S8: if (cancel) state_nxt = S1;
                else if (confirm) begin ld_nib[3] = 1'b1; state_nxt = S9; end
            S9: if (cancel) state_nxt = S1;
                else if (confirm) begin ld_nib[2] = 1'b1; state_nxt = S10; end
            S10: if (cancel) state_nxt = S1;
                else if (confirm) begin ld_nib[1] = 1'b1; state_nxt = S12; end
            S12: if (cancel) state_nxt = S1;
                else if (confirm) begin ld_nib[0] = 1'b1; start_nxt = 1'b1; state_nxt = S14; end
            S14: begin
                if (bus.Exec_Done) begin
                    ld_res    = 1'b1;
                    state_nxt = S15;
                end
`ifdef IO_SEQ_EXEC_TIMEOUT_EN
                else if (cancel) state_nxt = S1;
                else if (to_cnt == '0) begin
                    to_hit    = 1'b1;
                    state_nxt = S15;
                end
`endif
            end
            default: state_nxt = S1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_addr   <= 4'd0;
            mem_wdata  <= 8'd0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            exec_start <= 1'b0;
            rd_pend    <= 1'b0;
            read_reg   <= 8'd0;
            instr      <= 16'd0;
            res_reg    <= 16'd0;
        end else begin
            mem_we     <= we_nxt;
            mem_re     <= re_nxt;
            exec_start <= start_nxt;
            // Read data arrives the cycle after the strobe is seen.
            rd_pend    <= mem_re;
            if (rd_pend)   read_reg         <= bus.Mem_Rdata;
            if (ld_addr)   mem_addr         <= Slide_Switch;
            if (ld_wdata)  mem_wdata        <= {4'd0, Slide_Switch};
            if (ld_nib[3]) instr[15:12]     <= Slide_Switch;
            if (ld_nib[2]) instr[11:8]      <= Slide_Switch;
            if (ld_nib[1]) instr[7:4]       <= Slide_Switch;
            if (ld_nib[0]) instr[3:0]       <= Slide_Switch;
            if (ld_res)    res_reg          <= bus.Exec_Result;
`ifdef IO_SEQ_EXEC_TIMEOUT_EN
            else if (to_hit) res_reg        <= 16'hEEEE;
`endif
        end
    end

`ifdef IO_SEQ_EXEC_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt   <= '0;
            exec_err <= 1'b0;
        end else begin
            if (start_nxt)                        to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
            else if (state == S14 && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
            if (to_hit)                               exec_err <= 1'b1;
            else if (state == S15 && state_nxt != S15) exec_err <= 1'b0;
        end
    end
    assign Exec_Err = exec_err;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign Exec_Err = 1'b0;
`endif

    always_comb begin
        Result = {12'd0, Slide_Switch};
        case (state)
            S0:      Result = 16'd0;
            S4:      Result = {12'd0, mem_wdata[3:0]};
            S6:      Result = {8'd0, read_reg};
            S14:     Result = instr;
            S15:     Result = res_reg;
            default: Result = {12'd0, Slide_Switch};
        endcase
    end

    assign State          = state;
    assign bus.Mem_Addr   = mem_addr;
    assign bus.Mem_Wdata  = mem_wdata;
    assign bus.Mem_We     = mem_we;
    assign bus.Mem_Re     = mem_re;
    assign bus.Instr      = instr;
    assign bus.Exec_Start = exec_start;
endmodule

// File: tb/tb_io_sequencer.sv
module tb_io_sequencer;
    localparam int DB = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sw = 4'h9;
    logic [3:0]  btn = 4'h0;
    logic [3:0]  state;
    logic [15:0] result;
    logic        exec_err;

    io_sequencer_if bus();

    io_sequencer #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(1000)) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .Slide_Switch (sw),
        .Button       (btn),
        .bus          (bus),
        .State        (state),
        .Result       (result),
        .Exec_Err     (exec_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] q_wr[$];
    logic [15:0] q_ex[$];
    logic [15:0] q_res[$];
    logic [11:0] mon_wr;
    logic [15:0] mon_ex;

    int we_cnt = 0, re_cnt = 0, st_cnt = 0;
    logic prev_we = 0, prev_re = 0, prev_st = 0;

    // Register-file read port: data only valid in the cycle after Mem_Re.
    logic [7:0] rom [16];
    always @(posedge clk)
        bus.Mem_Rdata <= bus.Mem_Re ? rom[bus.Mem_Addr] : 8'hA5;

    // Execution datapath: Done dp_delay cycles after Exec_Start (0 = same cycle).
    logic        dp_auto = 0;
    int          dp_delay = 0;
    int          dp_cnt = 0;
    logic [15:0] dp_result = 16'h0;
    always @(negedge clk) begin
        bus.Exec_Done = 1'b0;
        if (dp_cnt == 1) begin
            bus.Exec_Done   = 1'b1;
            bus.Exec_Result = dp_result;
        end
        if (dp_cnt != 0) dp_cnt--;
        if (dp_auto && bus.Exec_Start) begin
            if (dp_delay == 0) begin
                bus.Exec_Done   = 1'b1;
                bus.Exec_Result = dp_result;
            end else dp_cnt = dp_delay;
        end
    end

    // Strobe monitor: pops expected writes/issues from the scoreboards.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.Mem_We) begin
                we_cnt++;
                checks++;
                if (q_wr.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write: unexpected write addr=%h data=%h", bus.Mem_Addr, bus.Mem_Wdata);
                end else begin
                    mon_wr = q_wr.pop_front();
                    if ({bus.Mem_Addr, bus.Mem_Wdata} !== mon_wr) begin
                        errors++;
                        $display("FAIL mem_write: got addr/data %h, expected %h", {bus.Mem_Addr, bus.Mem_Wdata}, mon_wr);
                    end
                end
            end
            if (bus.Exec_Start) begin
                st_cnt++;
                checks++;
                if (q_ex.size() == 0) begin
                    errors++;
                    $display("FAIL exec_issue: unexpected Exec_Start instr=%h", bus.Instr);
                end else begin
                    mon_ex = q_ex.pop_front();
                    if (bus.Instr !== mon_ex) begin
                        errors++;
                        $display("FAIL exec_issue: got instr %h, expected %h", bus.Instr, mon_ex);
                    end
                end
            end
            if (bus.Mem_Re) re_cnt++;
            if (bus.Mem_We || bus.Mem_Re || bus.Exec_Start) begin
                checks++;
                if ((int'(bus.Mem_We) + int'(bus.Mem_Re) + int'(bus.Exec_Start)) != 1 ||
                    (bus.Mem_We && prev_we) || (bus.Mem_Re && prev_re) || (bus.Exec_Start && prev_st)) begin
                    errors++;
                    $display("FAIL strobe_shape: we=%b re=%b start=%b prev=%b%b%b, expected single one-cycle strobe",
                             bus.Mem_We, bus.Mem_Re, bus.Exec_Start, prev_we, prev_re, prev_st);
                end
            end
        end
        prev_we = bus.Mem_We;
        prev_re = bus.Mem_Re;
        prev_st = bus.Exec_Start;
    end

    task automatic press(input logic [3:0] mask);
        btn = mask;
        repeat (DB + 10) @(negedge clk);
        btn = 4'h0;
        repeat (DB + 10) @(negedge clk);
    endtask

    task automatic enter(input logic [3:0] s, input logic [3:0] mask);
        sw = s;
        press(mask);
    endtask

    task automatic chk_state(input string name, input logic [3:0] exp);
        checks++;
        if (state !== exp) begin
            errors++;
            $display("FAIL %s: State=%0d, expected %0d", name, state, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 4'd0 || result !== 16'd0) begin
            errors++;
            $display("FAIL reset_out: State=%0d Result=%h, expected 0/0000", state, result);
        end
        checks++;
        if ({bus.Mem_We, bus.Mem_Re, bus.Exec_Start, exec_err} !== 4'b0 || bus.Instr !== 16'd0 ||
            bus.Mem_Addr !== 4'd0 || bus.Mem_Wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: strobes/err=%b instr=%h addr=%h wdata=%h, expected all zero",
                     {bus.Mem_We, bus.Mem_Re, bus.Exec_Start, exec_err}, bus.Instr, bus.Mem_Addr, bus.Mem_Wdata);
        end
        rst_n = 1'b1;
        #1 chk_state("reset_s0_hold", 4'd0);
        @(negedge clk);
        chk_state("reset_to_s1", 4'd1);
        checks++;
        if (result !== 16'h0009) begin
            errors++;
            $display("FAIL idle_result: Result=%h, expected 0009", result);
        end
    endtask

    task automatic test_save();
        int we0;
        we0 = we_cnt;
        enter(4'h1, 4'b0001); chk_state("save_s2", 4'd2);
        enter(4'hA, 4'b0001); chk_state("save_s3", 4'd3);
        q_wr.push_back({4'hA, 8'h05});
        enter(4'h5, 4'b0001); chk_state("save_s4", 4'd4);
        sw = 4'hF;
        @(negedge clk);
        checks++;
        if (result !== 16'h0005) begin
            errors++;
            $display("FAIL save_result: Result=%h, expected 0005", result);
        end
        checks++;
        if (we_cnt !== we0 + 1) begin
            errors++;
            $display("FAIL save_we_count: %0d writes, expected 1", we_cnt - we0);
        end
        enter(4'h0, 4'b0001); chk_state("save_exit", 4'd1);
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [15:0] exp_res, input logic [3:0] exit_mask);
        logic [15:0] exp;
        int re0;
        re0 = re_cnt;
        enter(4'h2, 4'b0001); chk_state("read_s5", 4'd5);
        q_res.push_back(exp_res);
        enter(addr, 4'b0001); chk_state("read_s6", 4'd6);
        exp = q_res.pop_front();
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL read_result: Result=%h, expected %h", result, exp);
        end
        checks++;
        if (re_cnt !== re0 + 1) begin
            errors++;
            $display("FAIL read_re_count: %0d reads, expected 1", re_cnt - re0);
        end
        enter(4'h0, exit_mask); chk_state("read_exit", 4'd1);
    endtask

    task automatic test_read();
        do_read(4'hA, 16'h003C, 4'b0001);
        do_read(4'h3, 16'h0033, 4'b0010);
    endtask

    task automatic enter_instr(input logic [15:0] ins);
        enter(4'h3, 4'b0001);     chk_state("instr_s8", 4'd8);
        enter(ins[15:12], 4'b0001); chk_state("instr_s9", 4'd9);
        enter(ins[11:8], 4'b0001);  chk_state("instr_s10", 4'd10);
        enter(ins[7:4], 4'b0001);   chk_state("instr_s12", 4'd12);
        q_ex.push_back(ins);
        enter(ins[3:0], 4'b0001);
    endtask

    task automatic test_instr();
        int st0;
        st0 = st_cnt;
        dp_auto = 1; dp_delay = 7; dp_result = 16'hBEEF;
        enter_instr(16'h1234);
        chk_state("instr_s15", 4'd15);
        checks++;
        if (result !== 16'hBEEF || bus.Instr !== 16'h1234) begin
            errors++;
            $display("FAIL instr_result: Result=%h Instr=%h, expected BEEF/1234", result, bus.Instr);
        end
        checks++;
        if (st_cnt !== st0 + 1) begin
            errors++;
            $display("FAIL instr_start_count: %0d starts, expected 1", st_cnt - st0);
        end
        dp_auto = 0;
        enter(4'h0, 4'b0001); chk_state("instr_exit", 4'd1);
    endtask

    task automatic test_bounce();
        int hi[4] = '{60, 150, 30, 180};
        sw = 4'h3;
        foreach (hi[k]) begin
            btn = 4'b0001;
            repeat (hi[k]) @(negedge clk);
            btn = 4'b0000;
            repeat (20) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk_state("bounce_rejected", 4'd1);
        btn = 4'b0001;
        repeat (500) @(negedge clk);
        btn = 4'b0000;
        repeat (DB + 10) @(negedge clk);
        chk_state("bounce_one_event", 4'd8);
        enter(4'h5, 4'b0001); chk_state("bounce_s9", 4'd9);
        enter(4'h0, 4'b0011); chk_state("both_cancel_wins", 4'd1);
        checks++;
        if (bus.Instr !== 16'h5234) begin
            errors++;
            $display("FAIL cancel_instr_keep: Instr=%h, expected 5234", bus.Instr);
        end
    endtask

    task automatic test_cancel();
        int we0, st0;
        we0 = we_cnt; st0 = st_cnt;
        enter(4'h1, 4'b0001); chk_state("cancel_s2", 4'd2);
        enter(4'h7, 4'b0010); chk_state("cancel_from_s2", 4'd1);
        checks++;
        if (we_cnt !== we0 || bus.Mem_Addr !== 4'h3) begin
            errors++;
            $display("FAIL cancel_no_write: writes=%0d addr=%h, expected 0/3", we_cnt - we0, bus.Mem_Addr);
        end
        enter(4'h7, 4'b0001); chk_state("bad_mode_stay", 4'd1);
        checks++;
        if (result !== 16'h0007) begin
            errors++;
            $display("FAIL idle_live: Result=%h, expected 0007", result);
        end
        enter(4'h3, 4'b0001); enter(4'h6, 4'b0001); chk_state("cancel_s9", 4'd9);
        enter(4'h0, 4'b0010); chk_state("cancel_from_s9", 4'd1);
        checks++;
        if (bus.Instr !== 16'h6234 || st_cnt !== st0) begin
            errors++;
            $display("FAIL cancel_instr: Instr=%h starts=%0d, expected 6234/0", bus.Instr, st_cnt - st0);
        end
    endtask

`ifdef IO_SEQ_EXEC_TIMEOUT_EN
    task automatic test_timeout();
        dp_auto = 0;
        enter_instr(16'h9876);
        chk_state("to_s14", 4'd14);
        for (int i = 0; i < 1200 && state !== 4'd15; i++) @(negedge clk);
        chk_state("to_reach_s15", 4'd15);
        checks++;
        if (result !== 16'hEEEE || exec_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: Result=%h Exec_Err=%b, expected EEEE/1", result, exec_err);
        end
        enter(4'h0, 4'b0001); chk_state("to_exit", 4'd1);
        checks++;
        if (exec_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: Exec_Err=%b, expected 0", exec_err);
        end
        enter_instr(16'h1111);
        chk_state("to_s14_again", 4'd14);
        enter(4'h0, 4'b0010); chk_state("to_cancel_s14", 4'd1);
    endtask
`else
    task automatic test_s14_wait();
        dp_auto = 0;
        enter_instr(16'h9876);
        chk_state("wait_s14", 4'd14);
        checks++;
        if (result !== 16'h9876) begin
            errors++;
            $display("FAIL s14_result: Result=%h, expected 9876", result);
        end
        enter(4'h0, 4'b0010); chk_state("s14_cancel_ignored", 4'd14);
        repeat (700) @(negedge clk);
        chk_state("s14_no_timeout", 4'd14);
        checks++;
        if (exec_err !== 1'b0) begin
            errors++;
            $display("FAIL exec_err_off: Exec_Err=%b, expected 0", exec_err);
        end
        dp_result = 16'h1357;
        dp_cnt = 1;
        repeat (2) @(negedge clk);
        chk_state("late_done_s15", 4'd15);
        checks++;
        if (result !== 16'h1357) begin
            errors++;
            $display("FAIL late_done_result: Result=%h, expected 1357", result);
        end
        enter(4'h0, 4'b0001); chk_state("late_exit", 4'd1);
    endtask
`endif

    task automatic test_back_to_back();
        dp_auto = 1; dp_delay = 0; dp_result = 16'hCAFE;
        enter_instr(16'h4321);
        chk_state("b2b_s15", 4'd15);
        checks++;
        if (result !== 16'hCAFE) begin
            errors++;
            $display("FAIL b2b_result: Result=%h, expected CAFE", result);
        end
        dp_auto = 0;
        enter(4'h0, 4'b0010); chk_state("s15_cancel_exit", 4'd1);
    endtask

    task automatic test_reset_mid();
        enter(4'h3, 4'b0001); enter(4'h1, 4'b0001); chk_state("mid_s9", 4'd9);
        #2 rst_n = 1'b0;
        #1;
        chk_state("mid_reset_async", 4'd0);
        checks++;
        if (bus.Instr !== 16'd0 || result !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_regs: Instr=%h Result=%h, expected 0/0", bus.Instr, result);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk_state("mid_s0_hold", 4'd0);
        @(negedge clk);
        chk_state("mid_to_s1", 4'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = {i[3:0], i[3:0]};
        rom[10] = 8'h3C;
        bus.Exec_Done   = 1'b0;
        bus.Exec_Result = 16'h0;
        test_reset();
        test_save();
        test_read();
        test_instr();
        test_bounce();
        test_cancel();
`ifdef IO_SEQ_EXEC_TIMEOUT_EN
        test_timeout();
`else
        test_s14_wait();
`endif
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (q_wr.size() != 0 || q_ex.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d writes and %0d issues never seen, expected 0/0", q_wr.size(), q_ex.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
